// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle sequencing FSM for the RV32I core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, latches the
// opcode class in DECODE and drives the datapath enables and mux selects.
// Optional build macro PERF_CNT_EN adds the CycleCnt/InstRet counters.
module rv_multicycle_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0,
  parameter int         IMM_TYPE_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            Opcode,
  input  logic                  IMemAck,
  input  logic                  DMemAck,
  input  logic                  BranchTaken,
  output logic                  IMemReq,
  output logic                  DMemReq,
  output logic                  DMemWrite,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  PCSel,
  output logic                  RegWrite,
  output logic [1:0]            WBSel,
  output logic                  ALUSrcA,
  output logic                  ALUSrcB,
  output logic [IMM_TYPE_W-1:0] ImmType,
  output logic                  Halted,
  output logic [2:0]            State
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]           CycleCnt,
  output logic [31:0]           InstRet
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // Class codes double as the immediate generator's format select.
  typedef enum logic [2:0] {
    C_RTYPE  = 3'd0,
    C_ITYPE  = 3'd1,
    C_STYPE  = 3'd2,
    C_BTYPE  = 3'd3,
    C_UTYPE  = 3'd4,
    C_JTYPE  = 3'd5,
    C_LITYPE = 3'd6,
    C_LJTYPE = 3'd7
  } cls_t;

  state_t state, state_next;
  cls_t   cls, dec_cls;
  logic   is_auipc, dec_auipc, dec_valid;
  logic   sel_a, sel_b;

  // Classify the opcode presented by the IR; only consumed in DECODE.
  always_comb begin
    dec_valid = 1'b1;
    dec_cls   = C_RTYPE;
    dec_auipc = 1'b0;
    case (Opcode)
      7'b0110011: dec_cls = C_RTYPE;
      7'b0010011: dec_cls = C_ITYPE;
      7'b0000011: dec_cls = C_LITYPE;
      7'b0100011: dec_cls = C_STYPE;
      7'b1100011: dec_cls = C_BTYPE;
      7'b0110111: dec_cls = C_UTYPE;
      7'b0010111: begin
        dec_cls   = C_UTYPE;
        dec_auipc = 1'b1;
      end
      7'b1101111: dec_cls = C_JTYPE;
      7'b1100111: dec_cls = C_LJTYPE;
      default:    dec_valid = 1'b0;
    endcase
  end

  // Latch the instruction class (and AUIPC vs LUI) while in DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls      <= C_RTYPE;
      is_auipc <= 1'b0;
    end else if (state == S_DECODE && dec_valid) begin
      cls      <= dec_cls;
      is_auipc <= dec_auipc;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= state_t'(RESET_STATE);
    else     state <= state_next;
  end

  // ALU operand selects follow the latched class.
  always_comb begin
    sel_a = (cls == C_BTYPE) || (cls == C_JTYPE) || (cls == C_UTYPE && is_auipc);
    sel_b = !((cls == C_RTYPE) || (cls == C_BTYPE));
  end

  // Next-state and datapath controls; everything is forced low during reset.
  always_comb begin
    state_next = state;
    IMemReq    = 1'b0;
    DMemReq    = 1'b0;
    DMemWrite  = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSel      = 1'b0;
    RegWrite   = 1'b0;
    WBSel      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 1'b0;
    ImmType    = '0;
    Halted     = 1'b0;
    State      = state;
    case (state)
      S_FETCH: begin
        IMemReq = 1'b1;
        if (IMemAck) begin
          IRWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_valid) begin
          ImmType    = IMM_TYPE_W'(dec_cls);
          state_next = S_EXEC;
        end else begin
          state_next = S_TRAP;
        end
      end
      S_EXEC: begin
        ImmType = IMM_TYPE_W'(cls);
        ALUSrcA = sel_a;
        ALUSrcB = sel_b;
        if (cls == C_BTYPE) begin
          PCWrite    = 1'b1;
          PCSel      = BranchTaken;
          state_next = S_FETCH;
        end else if (cls == C_LITYPE || cls == C_STYPE) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        ImmType   = IMM_TYPE_W'(cls);
        ALUSrcA   = sel_a;
        ALUSrcB   = sel_b;
        DMemReq   = 1'b1;
        DMemWrite = (cls == C_STYPE);
        if (DMemAck) begin
          if (cls == C_STYPE) begin
            PCWrite    = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        ImmType    = IMM_TYPE_W'(cls);
        ALUSrcA    = sel_a;
        ALUSrcB    = sel_b;
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        PCSel      = (cls == C_JTYPE) || (cls == C_LJTYPE);
        if (cls == C_LITYPE)                         WBSel = 2'b01;
        else if (cls == C_JTYPE || cls == C_LJTYPE)  WBSel = 2'b10;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        Halted = 1'b1;
      end
      default: begin
        state_next = S_TRAP;
      end
    endcase
    if (rst) begin
      IMemReq   = 1'b0;
      DMemReq   = 1'b0;
      DMemWrite = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSel     = 1'b0;
      RegWrite  = 1'b0;
      WBSel     = 2'b00;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ImmType   = '0;
      Halted    = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  // Count live cycles and instructions retired on return to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CycleCnt <= '0;
      InstRet  <= '0;
    end else begin
      if (state != S_TRAP) CycleCnt <= CycleCnt + 32'd1;
      if (state_next == S_FETCH &&
          (state == S_EXEC || state == S_MEM || state == S_WB))
        InstRet <= InstRet + 32'd1;
    end
  end
`endif

endmodule
